// File: rtl/lp_tableau_arbiter_if.sv
// Purpose: request/grant bundle between the LP cores, the tableau memory port and the arbiter.
// Latency: none, wires only.
// Backpressure: the memory port paces a burst through beat; stop aborts the current grant.
interface lp_tableau_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int BURST_W     = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*BURST_W-1:0] burst_len;
  logic                       beat;
  logic                       stop;
  logic [NUM_REQ-1:0]         gnt;
  logic [LOG_NUM_REQ-1:0]     mux_sel;
  logic [LOG_NUM_REQ-1:0]     demux_sel;
  logic                       demux_valid;
  logic                       busy;
  logic                       done;
  logic                       timeout;
  logic                       err;

  // Cores and memory port side: drives requests and beat/stop.
  modport master (
    output req, burst_len, beat, stop,
    input  gnt, mux_sel, demux_sel, demux_valid, busy, done, timeout, err
  );

  // Arbiter side.
  modport slave (
    input  req, burst_len, beat, stop,
    output gnt, mux_sel, demux_sel, demux_valid, busy, done, timeout, err
  );
endinterface

// File: rtl/lp_tableau_arbiter.sv
// Purpose: round-robin arbiter sharing the tableau memory port among the LP cores, one burst per grant.
// Latency: grant 1 cycle after req is seen; read returns appear RD_LAT cycles after each beat.
// Backpressure: a burst advances only on beat; stop aborts it; the watchdog ends a grant idle for TIMEOUT cycles.
module lp_tableau_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOG_NUM_REQ = 2,
  parameter int BURST_W     = 8,
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT     = 255
) (
  input logic                aclk,
  input logic                aresetn,
  lp_tableau_arbiter_if.slave io_bus
);
  // The watchdog never counts past TIMEOUT-1.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [0:0] {S_IDLE, S_GRANT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LOG_NUM_REQ-1:0] r_last;
  logic [LOG_NUM_REQ-1:0] r_mux_sel;
  logic [NUM_REQ-1:0]     r_gnt;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_timeout;
  logic                   r_err;
  logic [BURST_W-1:0]     r_beats_left;
  logic [WD_W-1:0]        r_wdog;
  logic [RD_LAT-1:0]      r_pv;
  logic [LOG_NUM_REQ-1:0] r_ps [RD_LAT];

  logic                   w_found;
  logic [LOG_NUM_REQ-1:0] w_idx;
  logic [LOG_NUM_REQ-1:0] w_cand;
  logic [BURST_W-1:0]     w_len_sel;
  logic                   w_start;
  logic                   w_fin_done;
  logic                   w_fin_to;
  logic                   w_fin_stop;
  logic                   w_beat_ok;

  assign w_beat_ok = io_bus.beat & r_busy;

  // Round-robin pick: first requesting core searching upward from last+1, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = LOG_NUM_REQ'((int'(r_last) + k) % NUM_REQ);
      if (!w_found && io_bus.req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // Burst length field of the core about to be granted.
  always_comb begin
    w_len_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == LOG_NUM_REQ'(i)) w_len_sel = io_bus.burst_len[i*BURST_W +: BURST_W];
    end
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state and end-of-grant causes; stop outranks completion, completion outranks the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fin_done  = 1'b0;
    w_fin_to    = 1'b0;
    w_fin_stop  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!io_bus.stop && w_found) begin
          w_start     = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (io_bus.stop) begin
          w_fin_stop  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (io_bus.beat) begin
          if (r_beats_left == BURST_W'(1)) begin
            w_fin_done  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_wdog == WD_W'(TIMEOUT - 1)) begin
          w_fin_to    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, beat counter, watchdog and status flags; mux_sel keeps the last granted core.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_gnt        <= '0;
      r_mux_sel    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_err        <= 1'b0;
      r_beats_left <= '0;
      r_wdog       <= '0;
      r_last       <= LOG_NUM_REQ'(NUM_REQ - 1);
    end else begin
      r_done    <= w_fin_done;
      r_timeout <= w_fin_to;
      if (w_fin_to) r_err <= 1'b1;
      if (w_start) begin
        r_gnt        <= NUM_REQ'(1) << w_idx;
        r_mux_sel    <= w_idx;
        r_busy       <= 1'b1;
        r_beats_left <= (w_len_sel == '0) ? BURST_W'(1) : w_len_sel;
        r_wdog       <= '0;
        r_last       <= w_idx;
      end else if (w_fin_done || w_fin_to || w_fin_stop) begin
        r_gnt  <= '0;
        r_busy <= 1'b0;
      end else if (r_state == S_GRANT) begin
        if (io_bus.beat) begin
          r_beats_left <= r_beats_left - BURST_W'(1);
          r_wdog       <= '0;
        end else begin
          r_wdog <= r_wdog + WD_W'(1);
        end
      end
    end
  end

  // Read-return shift register; each sel stage only loads with a valid entry so the head holds its last core.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pv <= '0;
      for (int k = 0; k < RD_LAT; k++) r_ps[k] <= '0;
    end else begin
      r_pv[0] <= w_beat_ok;
      if (w_beat_ok) r_ps[0] <= r_mux_sel;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) r_ps[k] <= r_ps[k-1];
      end
    end
  end

  assign io_bus.gnt         = r_gnt;
  assign io_bus.mux_sel     = r_mux_sel;
  assign io_bus.demux_sel   = r_ps[RD_LAT-1];
  assign io_bus.demux_valid = r_pv[RD_LAT-1];
  assign io_bus.busy        = r_busy;
  assign io_bus.done        = r_done;
  assign io_bus.timeout     = r_timeout;
  assign io_bus.err         = r_err;
endmodule

// File: tb/tb_lp_tableau_arbiter.sv
// Purpose: self-checking bench for lp_tableau_arbiter: transaction-level model plus directed scenarios.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: beat and stop driven directly from the stimulus.
module tb_lp_tableau_arbiter;
  localparam int NR = 4;
  localparam int LW = 2;
  localparam int BW = 8;
  localparam int RL = 2;
  localparam int TO = 16;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  logic [BW-1:0] bl [NR];

  always #5 aclk = ~aclk;

  lp_tableau_arbiter_if #(.NUM_REQ(NR), .LOG_NUM_REQ(LW), .BURST_W(BW)) bus();

  assign bus.burst_len = {bl[3], bl[2], bl[1], bl[0]};

  lp_tableau_arbiter #(.NUM_REQ(NR), .LOG_NUM_REQ(LW), .BURST_W(BW), .RD_LAT(RL), .TIMEOUT(TO)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .io_bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; int core;} ret_t;
  ret_t m_q[$];
  int m_owner, m_left, m_wd, m_last, m_edge;
  logic [LW-1:0] m_mux, m_ds, ci;
  logic m_done, m_to, m_err, m_dv;

  // Model: who owns the port, beats left, idle count, and a queue of scheduled read returns.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_owner = -1; m_left = 0; m_wd = 0; m_last = NR - 1; m_edge = 0;
      m_q.delete();
      m_mux = '0; m_ds = '0; m_done = 1'b0; m_to = 1'b0; m_err = 1'b0; m_dv = 1'b0;
    end else begin
      m_edge++;
      if (bus.beat && m_owner >= 0) m_q.push_back('{due: m_edge + RL - 1, core: m_owner});
      m_done = 1'b0;
      m_to   = 1'b0;
      if (m_owner >= 0) begin
        if (bus.stop) m_owner = -1;
        else if (bus.beat) begin
          m_left--;
          m_wd = 0;
          if (m_left == 0) begin m_owner = -1; m_done = 1'b1; end
        end else if (m_wd == TO - 1) begin
          m_owner = -1; m_to = 1'b1; m_err = 1'b1;
        end else m_wd++;
      end else if (!bus.stop) begin
        for (int k = 1; k <= NR; k++) begin
          ci = LW'((m_last + k) % NR);
          if (m_owner < 0 && bus.req[ci]) begin
            m_owner = int'(ci);
            m_left  = (bl[ci] == '0) ? 1 : int'(bl[ci]);
            m_wd    = 0;
            m_last  = int'(ci);
            m_mux   = ci;
          end
        end
      end
      if (m_q.size() > 0 && m_q[0].due == m_edge) begin
        m_dv = 1'b1;
        m_ds = LW'(m_q[0].core);
        void'(m_q.pop_front());
      end else m_dv = 1'b0;
    end
  end

  // ---------------- compare + observers ----------------
  logic [12:0] v_exp, v_act;
  logic [NR-1:0] prev_gnt = '0;
  int glog[$];
  int gcyc, done_cnt, to_cnt, cyc, first_gnt, first_dv;
  int dvc [NR];

  // Every cycle: DUT outputs against the model, then scenario counters.
  always begin
    @(posedge aclk);
    #1;
    v_exp = {((m_owner >= 0) ? (NR'(1) << m_owner) : NR'(0)), m_mux, m_ds, m_dv,
             (m_owner >= 0), m_done, m_to, m_err};
    v_act = {bus.gnt, bus.mux_sel, bus.demux_sel, bus.demux_valid,
             bus.busy, bus.done, bus.timeout, bus.err};
    chk("cycle{gnt,mux,dsel,dv,busy,done,to,err}", 32'(v_act), 32'(v_exp));
    cyc++;
    if (bus.gnt != '0 && prev_gnt == '0) begin
      for (int k = 0; k < NR; k++) if (bus.gnt[LW'(k)]) glog.push_back(k);
      if (first_gnt < 0) first_gnt = cyc;
    end
    prev_gnt = bus.gnt;
    if (bus.gnt != '0) gcyc++;
    if (bus.done) done_cnt++;
    if (bus.timeout) to_cnt++;
    if (bus.demux_valid) begin
      dvc[bus.demux_sel]++;
      if (first_dv < 0) first_dv = cyc;
    end
  end

  task automatic clr();
    glog.delete();
    gcyc = 0; done_cnt = 0; to_cnt = 0; first_gnt = -1; first_dv = -1;
    for (int k = 0; k < NR; k++) dvc[k] = 0;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; bus.req = '0; bus.beat = 1'b0; bus.stop = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  task automatic wait_glog(input int n, input int max_cyc);
    for (int t = 0; t < max_cyc && glog.size() < n; t++) @(negedge aclk);
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.beat = 1'b0; bus.stop = 1'b0;
    for (int k = 0; k < NR; k++) bl[k] = '0;
    clr();
    repeat (2) @(negedge aclk);
    chk("reset_outputs", {bus.gnt, bus.mux_sel, bus.demux_sel, bus.demux_valid,
                          bus.busy, bus.done, bus.timeout, bus.err}, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // 1: single 4-beat burst for core 1
    clr(); bl[1] = 8'd4; bus.req = 4'b0010; bus.beat = 1'b1;
    @(negedge aclk);
    chk("t1_gnt_after_1cycle", bus.gnt, 4'b0010);
    bus.req = '0;
    repeat (8) @(negedge aclk);
    chk("t1_gnt_cycles", gcyc, 4);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_returns_core1", dvc[1], 4);
    chk("t1_return_latency", first_dv - first_gnt, RL);

    // 2: all request, single-beat bursts, rotation from core 0
    do_reset(); clr();
    for (int k = 0; k < NR; k++) bl[k] = 8'd1;
    bus.req = 4'b1111; bus.beat = 1'b1;
    wait_glog(5, 40);
    bus.req = '0;
    repeat (4) @(negedge aclk);
    chk("t2_grant_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk($sformatf("t2_order%0d", i), glog[i], exp_order[i]);
    chk("t2_gnt_cycles", gcyc, 5);
    chk("t2_done_pulses", done_cnt, 5);

    // 3: zero burst length behaves as one beat
    clr(); bl[3] = 8'd0; bus.req = 4'b1000;
    wait_glog(1, 10);
    bus.req = '0;
    repeat (4) @(negedge aclk);
    chk("t3_winner", (glog.size() > 0) ? glog[0] : -1, 3);
    chk("t3_gnt_cycles", gcyc, 1);
    chk("t3_done_pulses", done_cnt, 1);
    chk("t3_busy_low", bus.busy, 0);

    // 4: watchdog on an idle grant, then rotation continues past core 2
    clr(); bus.beat = 1'b0; bus.req = 4'b0100;
    wait_glog(1, 10);
    bus.req = '0;
    repeat (20) @(negedge aclk);
    chk("t4_gnt_cycles", gcyc, TO);
    chk("t4_timeout_pulses", to_cnt, 1);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_err_set", bus.err, 1);
    clr(); bl[2] = 8'd1; bl[3] = 8'd1; bus.req = 4'b1100; bus.beat = 1'b1;
    wait_glog(1, 10);
    bus.req = '0;
    repeat (4) @(negedge aclk);
    chk("t4_next_winner", (glog.size() > 0) ? glog[0] : -1, 3);
    chk("t4_err_sticky", bus.err, 1);

    // 5: stop after two beats, stop in idle, stop together with a beat
    do_reset(); clr(); bl[0] = 8'd5; bus.req = 4'b0001; bus.beat = 1'b1;
    wait_glog(1, 10);
    repeat (2) @(negedge aclk);
    bus.stop = 1'b1; bus.beat = 1'b0;
    @(negedge aclk);
    bus.stop = 1'b0; bus.req = '0;
    repeat (6) @(negedge aclk);
    chk("t5_gnt_cycles", gcyc, 3);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_returns_core0", dvc[0], 2);
    clr(); bl[0] = 8'd1; bus.stop = 1'b1; bus.req = 4'b0001; bus.beat = 1'b1;
    @(negedge aclk);
    chk("t5_stop_blocks_idle", bus.gnt, 0);
    bus.stop = 1'b0;
    wait_glog(1, 10);
    bus.req = '0;
    repeat (4) @(negedge aclk);
    chk("t5_grant_after_stop", glog.size(), 1);
    clr(); bl[1] = 8'd3; bus.req = 4'b0010;
    wait_glog(1, 10);
    bus.req = '0;
    @(negedge aclk);
    bus.stop = 1'b1;
    @(negedge aclk);
    bus.stop = 1'b0; bus.beat = 1'b0;
    repeat (5) @(negedge aclk);
    chk("t5_stop_beat_recorded", dvc[1], 2);
    chk("t5_stop_beat_no_done", done_cnt, 0);

    // 6: asynchronous reset in the middle of an 8-beat burst
    clr(); bl[0] = 8'd8; bus.req = 4'b0001; bus.beat = 1'b1;
    wait_glog(1, 10);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0; bus.req = '0; bus.beat = 1'b0;
    #1;
    chk("t6_outputs_in_reset", {bus.gnt, bus.mux_sel, bus.demux_sel, bus.demux_valid,
                                bus.busy, bus.done, bus.timeout, bus.err}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    clr();
    for (int k = 0; k < NR; k++) bl[k] = 8'd1;
    bus.req = 4'b1111; bus.beat = 1'b1;
    wait_glog(1, 10);
    bus.req = '0;
    repeat (5) @(negedge aclk);
    chk("t6_first_winner", (glog.size() > 0) ? glog[0] : -1, 0);
    chk("t6_returns_after_reset", dvc[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end
endmodule
